// File: rtl/clock_pkg.sv
// Shared constants and the config request type for the clock-enable generator.
package clock_pkg;
    localparam int ACC_W_DEF = 24;
    localparam int CFG_CH_W  = 8;

    localparam logic [4*ACC_W_DEF-1:0] INC_INIT_DEF = {24'd1, 24'd1, 24'd1, 24'd1};
    // ch3..ch0: 10 Hz, 3.58 MHz, 5.37 MHz, 10.74 MHz off 21.477 MHz
    localparam logic [4*ACC_W_DEF-1:0] MOD_INIT_DEF = {24'd2147728, 24'd6, 24'd4, 24'd2};

    typedef struct packed {
        logic [CFG_CH_W-1:0]  ch;
        logic [ACC_W_DEF-1:0] inc;
        logic [ACC_W_DEF-1:0] mod;
    } cfg_t;
endpackage

// File: rtl/clock_ce_channel.sv
// One fractional divider: accumulator, wrap / half-period detect, config apply port.
module clock_ce_channel
    import clock_pkg::*;
#(
    parameter int               ACC_W   = ACC_W_DEF,
    parameter logic [ACC_W-1:0] INC_RST = 1,
    parameter logic [ACC_W-1:0] MOD_RST = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             apply,
    input  logic [ACC_W-1:0] new_inc,
    input  logic [ACC_W-1:0] new_mod,
    output logic             wrap,
    output logic             ce_p,
    output logic             ce_n
);
    logic [ACC_W-1:0] acc_q, acc_d, inc_q, inc_d, mod_q, mod_d;
    logic             ce_p_q, ce_p_d, ce_n_q, ce_n_d;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] half, resid;

    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, inc_q};
        half   = mod_q >> 1;
        resid  = sum[ACC_W-1:0] - mod_q;
        wrap   = en && !sync && (sum >= {1'b0, mod_q});
        acc_d  = acc_q;
        inc_d  = inc_q;
        mod_d  = mod_q;
        ce_p_d = 1'b0;
        ce_n_d = 1'b0;
        if (sync) begin
            acc_d = '0;
        end else if (en) begin
            if (wrap) begin
                acc_d  = resid;
                ce_p_d = 1'b1;
            end else begin
                acc_d  = sum[ACC_W-1:0];
                // half strobe only meaningful when a step cannot jump the midpoint and the end
                ce_n_d = (inc_q <= half) && (acc_q < half) && ({1'b0, half} <= sum);
            end
        end
        if (apply) begin
            inc_d = new_inc;
            mod_d = new_mod;
            if (acc_d >= new_mod) acc_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            inc_q  <= INC_RST;
            mod_q  <= MOD_RST;
            ce_p_q <= 1'b0;
            ce_n_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            inc_q  <= inc_d;
            mod_q  <= mod_d;
            ce_p_q <= ce_p_d;
            ce_n_q <= ce_n_d;
        end
    end

    assign ce_p = ce_p_q;
    assign ce_n = ce_n_q;
endmodule

// File: rtl/clock_ce_gen.sv
// NUM_CH fractional clock-enable dividers with a single-entry run-time config slot.
module clock_ce_gen
    import clock_pkg::*;
#(
    parameter int                      NUM_CH   = 4,
    parameter int                      ACC_W    = ACC_W_DEF,
    parameter int                      CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter logic [NUM_CH*ACC_W-1:0] INC_INIT = INC_INIT_DEF,
    parameter logic [NUM_CH*ACC_W-1:0] MOD_INIT = MOD_INIT_DEF
) (
    input  logic              clk21m,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_mod,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] ce_p,
    output logic [NUM_CH-1:0] ce_n
);
    cfg_t              pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic              cfg_err_q, cfg_err_d;
    logic              req_ok;
    logic [NUM_CH-1:0] wrap, apply;

    assign cfg_ready = !pend_vld_q;
    assign cfg_err   = cfg_err_q;

    always_comb begin
        req_ok = (cfg_inc != '0) && (cfg_inc < cfg_mod) && (int'(cfg_ch) < NUM_CH);
        apply  = '0;
        // a pending update lands only at a period boundary, or at once if the channel is idle
        for (int i = 0; i < NUM_CH; i++) begin
            apply[i] = pend_vld_q && (pend_q.ch == CFG_CH_W'(i)) && (sync || !ch_en[i] || wrap[i]);
        end
        pend_vld_d = pend_vld_q && !(|apply);
        pend_d     = pend_q;
        cfg_err_d  = 1'b0;
        if (cfg_valid && cfg_ready) begin
            if (req_ok) begin
                pend_vld_d = 1'b1;
                pend_d.ch  = CFG_CH_W'(cfg_ch);
                pend_d.inc = cfg_inc;
                pend_d.mod = cfg_mod;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clock_ce_channel #(
            .ACC_W  (ACC_W),
            .INC_RST(INC_INIT[i*ACC_W +: ACC_W]),
            .MOD_RST(MOD_INIT[i*ACC_W +: ACC_W])
        ) u_ch (
            .clk    (clk21m),
            .rst    (reset),
            .en     (ch_en[i]),
            .sync   (sync),
            .apply  (apply[i]),
            .new_inc(pend_q.inc),
            .new_mod(pend_q.mod),
            .wrap   (wrap[i]),
            .ce_p   (ce_p[i]),
            .ce_n   (ce_n[i])
        );
    end
endmodule

// File: tb/tb_clock_ce_gen.sv
// Bench for clock_ce_gen: arithmetic reference model compared every cycle, plus pinned cadences.
module tb_clock_ce_gen;
    localparam int NUM_CH = 4;
    localparam int ACC_W  = 24;
    localparam int CH_W   = 3;
    localparam logic [NUM_CH*ACC_W-1:0] INCI = {24'd1, 24'd1, 24'd1, 24'd1};
    localparam logic [NUM_CH*ACC_W-1:0] MODI = {24'd20, 24'd6, 24'd4, 24'd2};

    logic              clk21m = 1'b0;
    logic              reset = 1'b1;
    logic [NUM_CH-1:0] ch_en = '1;
    logic              sync = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [ACC_W-1:0]  cfg_inc = '0;
    logic [ACC_W-1:0]  cfg_mod = '0;
    logic              cfg_err;
    logic [NUM_CH-1:0] ce_p, ce_n;

    always #5 clk21m = ~clk21m;

    clock_ce_gen #(
        .NUM_CH(NUM_CH), .ACC_W(ACC_W), .CH_W(CH_W), .INC_INIT(INCI), .MOD_INIT(MODI)
    ) dut (
        .clk21m(clk21m), .reset(reset), .ch_en(ch_en), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_inc(cfg_inc), .cfg_mod(cfg_mod), .cfg_err(cfg_err),
        .ce_p(ce_p), .ce_n(ce_n)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Reference: phase as an integer, pulses = how many whole moduli the phase crosses.
    int                mod0[NUM_CH] = '{2, 4, 6, 20};
    int                m_acc[NUM_CH], m_inc[NUM_CH], m_mod[NUM_CH];
    logic [NUM_CH-1:0] m_p = '0, m_n = '0;
    logic              m_err = 1'b0;
    bit                m_pv = 1'b0;
    int                m_pch, m_pinc, m_pmod;

    always @(posedge clk21m or posedge reset) begin
        int s, nxt;
        bit rdy, applied;
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_acc[i] = 0; m_inc[i] = 1; m_mod[i] = mod0[i];
            end
            m_p = '0; m_n = '0; m_err = 1'b0; m_pv = 1'b0;
        end else begin
            rdy = !m_pv;
            applied = 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                s = m_acc[i] + m_inc[i];
                nxt = m_acc[i];
                m_p[i] = 1'b0;
                m_n[i] = 1'b0;
                if (sync) nxt = 0;
                else if (ch_en[i]) begin
                    nxt = s % m_mod[i];
                    m_p[i] = (s / m_mod[i]) != 0;
                    m_n[i] = !m_p[i] && (m_inc[i] <= m_mod[i] / 2)
                             && (m_acc[i] < m_mod[i] / 2) && (s >= m_mod[i] / 2);
                end
                if (m_pv && m_pch == i && (sync || !ch_en[i] || m_p[i])) begin
                    m_inc[i] = m_pinc; m_mod[i] = m_pmod;
                    if (nxt >= m_mod[i]) nxt = 0;
                    applied = 1'b1;
                end
                m_acc[i] = nxt;
            end
            if (applied) m_pv = 1'b0;
            m_err = 1'b0;
            if (cfg_valid && rdy) begin
                if (cfg_inc != 0 && cfg_inc < cfg_mod && cfg_ch < NUM_CH) begin
                    m_pv = 1'b1; m_pch = int'(cfg_ch); m_pinc = int'(cfg_inc); m_pmod = int'(cfg_mod);
                end else m_err = 1'b1;
            end
        end
    end

    always @(negedge clk21m) begin
        chk("ce_p", 32'(ce_p), 32'(m_p));
        chk("ce_n", 32'(ce_n), 32'(m_n));
        chk("cfg_ready", 32'(cfg_ready), 32'(!m_pv));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
    end

    // Window statistics, edge index k counted from the last clear.
    int k;
    int pc[NUM_CH], nc[NUM_CH], fp[NUM_CH], fn[NUM_CH], lp[NUM_CH], gmin[NUM_CH], gmax[NUM_CH];

    task automatic clear_stats();
        k = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            pc[i] = 0; nc[i] = 0; fp[i] = -1; fn[i] = -1; lp[i] = -1; gmin[i] = 1000000; gmax[i] = 0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk21m);
            k++;
            for (int i = 0; i < NUM_CH; i++) begin
                if (ce_p[i]) begin
                    pc[i]++;
                    if (fp[i] < 0) fp[i] = k;
                    if (lp[i] >= 0) begin
                        if (k - lp[i] < gmin[i]) gmin[i] = k - lp[i];
                        if (k - lp[i] > gmax[i]) gmax[i] = k - lp[i];
                    end
                    lp[i] = k;
                end
                if (ce_n[i]) begin
                    nc[i]++;
                    if (fn[i] < 0) fn[i] = k;
                end
            end
        end
    endtask

    task automatic send_cfg(input int ch, input int inc, input int md);
        cfg_valid = 1'b1; cfg_ch = CH_W'(ch); cfg_inc = ACC_W'(inc); cfg_mod = ACC_W'(md);
        run(1);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_apply(input int ch, input string nm);
        int t;
        t = 0;
        while (cfg_ready !== 1'b1 && t < 200) begin
            run(1);
            t++;
        end
        chk({nm, " ready back"}, 32'(cfg_ready), 1);
        chk({nm, " applied on wrap"}, 32'(ce_p[ch]), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk21m);
        chk("rst ce_p", 32'(ce_p), 0);
        chk("rst ce_n", 32'(ce_n), 0);
        chk("rst cfg_ready", 32'(cfg_ready), 1);
        chk("rst cfg_err", 32'(cfg_err), 0);

        reset = 1'b0;
        clear_stats(); run(40);
        chk("first ce_p ch0", fp[0], 2);
        chk("first ce_p ch1", fp[1], 4);
        chk("first ce_p ch2", fp[2], 6);
        chk("first ce_p ch3", fp[3], 20);
        chk("count ch0", pc[0], 20);
        chk("count ch1", pc[1], 10);
        chk("count ch3", pc[3], 2);
        chk("period ch2", 32'(gmin[2] == 6 && gmax[2] == 6), 1);
        chk("first ce_n ch2", fn[2], 3);
        chk("count ce_n ch2", nc[2], 7);

        run(3);
        sync = 1'b1; run(1);
        chk("sync ce_p quiet", 32'(ce_p), 0);
        chk("sync ce_n quiet", 32'(ce_n), 0);
        sync = 1'b0;
        clear_stats(); run(20);
        chk("resync ch0", fp[0], 2);
        chk("resync ch1", fp[1], 4);
        chk("resync ch2", fp[2], 6);
        chk("resync ch3", fp[3], 20);

        clear_stats(); run(1);
        ch_en[2] = 1'b0; run(7);
        ch_en[2] = 1'b1; run(20);
        chk("stretched ce_p ch2", fp[2], 11);
        chk("period after resume ch2", 32'(gmin[2] == 6 && gmax[2] == 6), 1);

        send_cfg(1, 3, 10);
        chk("cfg ch1 busy", 32'(cfg_ready), 0);
        wait_apply(1, "cfg ch1");
        clear_stats(); run(100);
        chk("ch1 3/10 count", pc[1], 30);
        chk("ch1 gaps 3..4", 32'(gmin[1] >= 3 && gmax[1] <= 4), 1);

        send_cfg(2, 1, 8);
        chk("cfg ch2 busy", 32'(cfg_ready), 0);
        wait_apply(2, "cfg ch2");
        clear_stats(); run(40);
        chk("ch2 first new period", fp[2], 8);
        chk("ch2 period 8", 32'(gmin[2] == 8 && gmax[2] == 8), 1);

        send_cfg(0, 0, 5);
        chk("err inc0", 32'(cfg_err), 1);
        chk("ready inc0", 32'(cfg_ready), 1);
        send_cfg(0, 5, 5);
        chk("err inc=mod", 32'(cfg_err), 1);
        send_cfg(4, 1, 5);
        chk("err bad ch", 32'(cfg_err), 1);
        run(1);
        chk("err one cycle", 32'(cfg_err), 0);
        clear_stats(); run(40);
        chk("ch0 untouched", 32'(gmin[0] == 2 && gmax[0] == 2), 1);
        chk("ch1 untouched", pc[1], 12);
        chk("ch2 untouched", 32'(gmin[2] == 8 && gmax[2] == 8), 1);

        send_cfg(3, 1, 7);
        chk("pending before reset", 32'(cfg_ready), 0);
        #2 reset = 1'b1;
        #1;
        chk("async rst ready", 32'(cfg_ready), 1);
        chk("async rst ce_p", 32'(ce_p), 0);
        @(negedge clk21m);
        reset = 1'b0;
        clear_stats(); run(25);
        chk("post rst ch2", fp[2], 6);
        chk("post rst ch3", fp[3], 20);
        chk("post rst ch3 count", pc[3], 1);

        for (int c = 0; c < 3000; c++) begin
            int md;
            for (int i = 0; i < NUM_CH; i++) ch_en[i] = ($urandom_range(7, 0) != 0);
            sync = ($urandom_range(63, 0) == 0);
            cfg_valid = ($urandom_range(3, 0) == 0);
            cfg_ch = CH_W'($urandom_range(4, 0));
            if ($urandom_range(15, 0) == 0) begin
                md = int'($urandom_range(24'hFFFFFF, 24'h800000));
                cfg_inc = ACC_W'($urandom_range(md, 24'h400000));
            end else begin
                md = int'($urandom_range(40, 1));
                cfg_inc = ACC_W'($urandom_range(md, 0));
            end
            cfg_mod = ACC_W'(md);
            run(1);
        end
        cfg_valid = 1'b0; sync = 1'b0; ch_en = '1;
        run(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
